// File: rtl/gba_video_timing.sv
// GBA 240x160 pixel timing and framebuffer scanout: pixel-enable divider, H/V raster counters,
// linear framebuffer read address, and 8-bit RGB/sync/blank outputs. Optional macro: VTG_TESTPATTERN_EN.
module gba_video_timing #(
  parameter int unsigned CE_DIV   = 4,
  parameter int unsigned H_ACTIVE = 240,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 24,
  parameter int unsigned H_BP     = 28,
  parameter int unsigned V_ACTIVE = 160,
  parameter int unsigned V_FP     = 16,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 48,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [14:0]       fb_data,
`ifdef VTG_TESTPATTERN_EN
  input  logic              test_pattern,
`endif
  output logic              ce_pix,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              HSync,
  output logic              VSync,
  output logic              HBlank,
  output logic              VBlank,
  output logic              vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCNT_W  = $clog2(H_TOTAL);
  localparam int unsigned VCNT_W  = $clog2(V_TOTAL);
  localparam int unsigned DIV_W   = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  if (CE_DIV < 2) begin : g_bad_ce_div
    $error("gba_video_timing: CE_DIV must be >= 2");
  end

  logic [DIV_W-1:0]  div_q, div_d;
  logic              ce_q, ce_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic              hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d, vbs_q, vbs_d;
  logic              h_act, v_act, active, h_last, v_last;
  logic [7:0]        px_r, px_g, px_b;

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q  <= '0;
      ce_q   <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      addr_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hb_q   <= 1'b0;
      vb_q   <= 1'b0;
      vbs_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      ce_q   <= ce_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      addr_q <= addr_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      hb_q   <= hb_d;
      vb_q   <= vb_d;
      vbs_q  <= vbs_d;
    end
  end

  // Colour of the pixel at the current counters; fb_data already reflects addr_q here.
  always_comb begin
    px_r = expand5(fb_data[4:0]);
    px_g = expand5(fb_data[9:5]);
    px_b = expand5(fb_data[14:10]);
`ifdef VTG_TESTPATTERN_EN
    if (test_pattern) begin
      px_r = 8'(hcnt_q);
      px_g = 8'(vcnt_q);
      px_b = 8'h80;
    end
`endif
    if (!active) begin
      px_r = 8'h00;
      px_g = 8'h00;
      px_b = 8'h00;
    end
  end

  always_comb begin
    h_act  = hcnt_q < HCNT_W'(H_ACTIVE);
    v_act  = vcnt_q < VCNT_W'(V_ACTIVE);
    active = h_act && v_act;
    h_last = hcnt_q == HCNT_W'(H_TOTAL - 1);
    v_last = vcnt_q == VCNT_W'(V_TOTAL - 1);

    div_d  = (div_q == DIV_W'(CE_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    ce_d   = div_q == DIV_W'(CE_DIV - 2);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    addr_d = addr_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    hb_d   = hb_q;
    vb_d   = vb_q;
    vbs_d  = 1'b0;

    // Latch pixel P's video, then advance the raster.
    if (ce_q) begin
      r_d   = px_r;
      g_d   = px_g;
      b_d   = px_b;
      hb_d  = !h_act;
      vb_d  = !v_act;
      hs_d  = (hcnt_q >= HCNT_W'(HS_BEG)) && (hcnt_q < HCNT_W'(HS_END));
      vs_d  = (vcnt_q >= VCNT_W'(VS_BEG)) && (vcnt_q < VCNT_W'(VS_END));
      vbs_d = !v_act && !vb_q;

      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + VCNT_W'(1);
      end else begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end

      if (h_last && v_last) begin
        addr_d = '0;
      end else if (active) begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  assign fb_addr      = addr_q;
  assign ce_pix       = ce_q;
  assign R            = r_q;
  assign G            = g_q;
  assign B            = b_q;
  assign HSync        = hs_q;
  assign VSync        = vs_q;
  assign HBlank       = hb_q;
  assign VBlank       = vb_q;
  assign vblank_start = vbs_q;

endmodule
